// File: rtl/bnn_dsram_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bnn_dsram_pkg
//  Purpose  : Shared types and field positions for the data-SRAM arbiter.
//             - dsram_state_e : arbiter ownership state
//             - DS_*          : bit positions inside the 15-bit datasram_ctrl
//                               bus driven by the BNN instruction controller
//  Revision : 1.0  initial release
// ============================================================================
package bnn_dsram_pkg;

    typedef enum logic [1:0] {
        CTRL    = 2'd0,
        DRAIN   = 2'd1,
        HOST    = 2'd2,
        RELEASE = 2'd3
    } dsram_state_e;

    // datasram_ctrl layout: [12:0] addr, [13] CEN (active-low), [14] WEN (0 = write)
    localparam int DS_ADDR_MSB = 12;
    localparam int DS_CEN_BIT  = 13;
    localparam int DS_WEN_BIT  = 14;
    localparam int DS_AW       = 13;

endpackage
`default_nettype wire

// File: rtl/dsram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dsram_arbiter
//  Purpose  : Shares the single-port data SRAM between the BNN instruction
//             controller and a host loader. The host is granted the port only
//             after the controller has been paused for one drain cycle, and
//             its tenure is bounded so the controller cannot be starved.
//  Ports    :
//    clk, rst                 clock, asynchronous active-low reset
//    ctrl_bus, ctrl_wdata     controller access ([12:0] addr, [13] CEN, [14] WEN)
//    ctrl_pause               pause request to the controller
//    host_req/we/addr/wdata/last, host_gnt   host access handshake
//    host_rvalid, host_rdata  host read return (1 cycle after accepted read)
//    sram_a/cen/wen/d, sram_q SRAM pins
//    core_rdata               sram_q passed through to the core
//    proto_err                sticky: controller accessed the SRAM while paused
//  Revision : 1.0  initial release
// ============================================================================
module dsram_arbiter
    import bnn_dsram_pkg::*;
#(
    parameter int AW             = DS_AW,
    parameter int DW             = 16,
    parameter int MAX_HOST_BURST = 8,
    parameter int MIN_CTRL_GAP   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DS_WEN_BIT:0]   ctrl_bus,
    input  logic [DW-1:0]         ctrl_wdata,
    output logic                  ctrl_pause,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [AW-1:0]         host_addr,
    input  logic [DW-1:0]         host_wdata,
    input  logic                  host_last,
    output logic                  host_gnt,
    output logic                  host_rvalid,
    output logic [DW-1:0]         host_rdata,
    output logic [AW-1:0]         sram_a,
    output logic                  sram_cen,
    output logic                  sram_wen,
    output logic [DW-1:0]         sram_d,
    input  logic [DW-1:0]         sram_q,
    output logic [DW-1:0]         core_rdata,
    output logic                  proto_err
);

    localparam int BCW = $clog2(MAX_HOST_BURST + 1);
    localparam int GCW = (MIN_CTRL_GAP > 0) ? $clog2(MIN_CTRL_GAP + 1) : 1;
    localparam logic [BCW-1:0] BURST_MAX = BCW'(MAX_HOST_BURST);
    localparam logic [GCW-1:0] GAP_LOAD  = GCW'(MIN_CTRL_GAP);

    dsram_state_e   state;
    dsram_state_e   next_state;
    logic [BCW-1:0] burst_cnt;
    logic [BCW-1:0] burst_next;
    logic [GCW-1:0] gap_cnt;
    logic           host_accept;
    logic           rd_valid;   // an SRAM read was issued last cycle
    logic           rd_owner;   // 1 = that read belonged to the host

    assign host_accept = (state == HOST) && host_req;
    assign burst_next  = burst_cnt + BCW'(1);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= CTRL;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next state and SRAM pin mux (selected by registered state)
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        host_gnt   = 1'b0;
        sram_a     = ctrl_bus[DS_ADDR_MSB:0];
        sram_cen   = ctrl_bus[DS_CEN_BIT];
        sram_wen   = ctrl_bus[DS_WEN_BIT];
        sram_d     = ctrl_wdata;

        case (state)
            CTRL: begin
                if (host_req && (gap_cnt == '0)) begin
                    next_state = DRAIN;
                end
            end
            // The controller may still issue one access while it reacts to
            // pause, so the pins keep following ctrl_bus here.
            DRAIN: begin
                next_state = HOST;
            end
            // Any controller access seen here is dropped (flagged below).
            HOST: begin
                host_gnt = 1'b1;
                sram_a   = host_addr;
                sram_d   = host_wdata;
                if (host_req) begin
                    sram_cen = 1'b0;
                    sram_wen = ~host_we;
                    if (host_last || (burst_next == BURST_MAX)) begin
                        next_state = RELEASE;
                    end
                end else begin
                    sram_cen   = 1'b1;
                    sram_wen   = 1'b1;
                    next_state = RELEASE;
                end
            end
            RELEASE: begin
                sram_cen   = 1'b1;
                sram_wen   = 1'b1;
                next_state = CTRL;
            end
            default: begin
                next_state = CTRL;
            end
        endcase

        // Keep the SRAM idle for as long as reset is held.
        if (!rst) begin
            sram_cen = 1'b1;
            sram_wen = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Counters, pause, protocol flag and read-return tag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            burst_cnt  <= '0;
            gap_cnt    <= '0;
            ctrl_pause <= 1'b0;
            proto_err  <= 1'b0;
            rd_valid   <= 1'b0;
            rd_owner   <= 1'b0;
        end else begin
            // Registered copy of the state decode so pause rises on DRAIN entry.
            ctrl_pause <= (next_state == DRAIN) || (next_state == HOST);

            if (state == RELEASE) begin
                burst_cnt <= '0;
            end else if (host_accept) begin
                burst_cnt <= burst_next;
            end

            if (state == RELEASE) begin
                gap_cnt <= GAP_LOAD;
            end else if ((state == CTRL) && (gap_cnt != '0)) begin
                gap_cnt <= gap_cnt - GCW'(1);
            end

            if ((state == HOST) && !ctrl_bus[DS_CEN_BIT]) begin
                proto_err <= 1'b1;
            end

            rd_valid <= !sram_cen && sram_wen;
            rd_owner <= (state == HOST);
        end
    end

    assign host_rvalid = rd_valid && rd_owner;
    assign host_rdata  = host_rvalid ? sram_q : '0;
    assign core_rdata  = sram_q;

endmodule
`default_nettype wire

// File: tb/tb_dsram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dsram_arbiter
//  Purpose  : Self-checking bench for dsram_arbiter. A behavioural SRAM model
//             sits on the pins; expected host read returns are queued when a
//             host read is issued and popped when host_rvalid appears.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dsram_arbiter;

    localparam int AW = 13;
    localparam int DW = 16;
    localparam logic [14:0] CB_IDLE = 15'h6000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [14:0]   ctrl_bus;
    logic [DW-1:0] ctrl_wdata;
    logic          ctrl_pause;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_last;
    logic          host_gnt;
    logic          host_rvalid;
    logic [DW-1:0] host_rdata;
    logic [AW-1:0] sram_a;
    logic          sram_cen;
    logic          sram_wen;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q = '0;
    logic [DW-1:0] core_rdata;
    logic          proto_err;

    dsram_arbiter #(
        .AW(AW), .DW(DW), .MAX_HOST_BURST(8), .MIN_CTRL_GAP(4)
    ) dut (
        .clk(clk), .rst(rst),
        .ctrl_bus(ctrl_bus), .ctrl_wdata(ctrl_wdata), .ctrl_pause(ctrl_pause),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_last(host_last), .host_gnt(host_gnt),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .sram_a(sram_a), .sram_cen(sram_cen), .sram_wen(sram_wen),
        .sram_d(sram_d), .sram_q(sram_q), .core_rdata(core_rdata),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // SRAM model: 1-cycle read latency, q holds between reads
    logic [DW-1:0] mem [0:8191];
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_wen) mem[sram_a] <= sram_d;
            else           sram_q      <= mem[sram_a];
        end
    end

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb[$];
    exp_t e_mon;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return {3'b000, a} ^ 16'hA5A5;
    endfunction

    function automatic logic [14:0] cb_rd(input logic [AW-1:0] a);
        return {1'b1, 1'b0, a};
    endfunction

    function automatic logic [14:0] cb_wr(input logic [AW-1:0] a);
        return {1'b0, 1'b0, a};
    endfunction

    task automatic drive_idle();
        ctrl_bus   = CB_IDLE;
        ctrl_wdata = '0;
        host_req   = 1'b0;
        host_we    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
        host_last  = 1'b0;
    endtask

    // Read-return scoreboard
    always @(negedge clk) begin
        #2;
        if (rst) begin
            if (host_rvalid) begin
                if (sb.size() == 0) begin
                    check("rvalid_unexpected", 32'(host_rvalid), 32'd0);
                end else begin
                    e_mon = sb.pop_front();
                    check("rvalid_cycle", cyc, e_mon.cyc);
                    check("rvalid_data", 32'(host_rdata), 32'(e_mon.data));
                end
            end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
                check("rvalid_missing", 32'(host_rvalid), 32'd1);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  idx;
        logic gnt_exp, pause_exp;

        for (int i = 0; i < 8192; i++) mem[i] = pat(AW'(i));
        mem[13'h040] = 16'hBEEF;

        // ---------------- reset values (controller write on the bus) ----
        drive_idle();
        ctrl_bus = cb_wr(13'h0005);
        #3;
        check("rst_pause", 32'(ctrl_pause), 0);
        check("rst_gnt", 32'(host_gnt), 0);
        check("rst_rvalid", 32'(host_rvalid), 0);
        check("rst_perr", 32'(proto_err), 0);
        check("rst_rdata", 32'(host_rdata), 0);
        check("rst_cen", 32'(sram_cen), 1);
        check("rst_wen", 32'(sram_wen), 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        drive_idle();

        // ---------------- controller reads pass straight through --------
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ctrl_bus = cb_rd(AW'(13'h0100 + i));
            #1;
            check("ctrl_a", 32'(sram_a), 32'h100 + i);
            check("ctrl_cen", 32'(sram_cen), 0);
            check("ctrl_wen", 32'(sram_wen), 1);
            check("ctrl_pause_low", 32'(ctrl_pause), 0);
            if (i > 0) check("core_rdata", 32'(core_rdata), 32'(pat(AW'(13'h0100 + i - 1))));
        end
        @(negedge clk);
        drive_idle();
        #1;
        check("core_rdata_last", 32'(core_rdata), 32'(pat(13'h0103)));

        // ---------------- host 4-write burst ----------------------------
        @(negedge clk);
        host_req = 1'b1; host_we = 1'b1; host_addr = 13'h0200; host_wdata = 16'hC000;
        #1;
        check("req_pause", 32'(ctrl_pause), 0);
        check("req_gnt", 32'(host_gnt), 0);
        @(negedge clk);
        #1;
        check("drain_pause", 32'(ctrl_pause), 1);
        check("drain_gnt", 32'(host_gnt), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            host_addr  = AW'(13'h0200 + i);
            host_wdata = 16'hC000 + 16'(i);
            host_last  = (i == 3);
            #1;
            check("wr_gnt", 32'(host_gnt), 1);
            check("wr_a", 32'(sram_a), 32'h200 + i);
            check("wr_cen", 32'(sram_cen), 0);
            check("wr_wen", 32'(sram_wen), 0);
            check("wr_d", 32'(sram_d), 32'hC000 + i);
        end
        @(negedge clk);
        drive_idle();
        #1;
        check("rel_gnt", 32'(host_gnt), 0);
        check("rel_pause", 32'(ctrl_pause), 0);
        check("rel_cen", 32'(sram_cen), 1);
        check("wr_mem", 32'(mem[13'h203]), 32'hC003);
        repeat (4) @(negedge clk);

        // ---------------- host read; controller read in DRAIN -----------
        @(negedge clk);
        host_req = 1'b1; host_we = 1'b0; host_addr = 13'h0040;
        ctrl_bus = cb_rd(13'h0100);
        #1;
        @(negedge clk);
        ctrl_bus = cb_rd(13'h0101);
        #1;
        check("drain_ctrl_a", 32'(sram_a), 32'h101);
        check("drain_ctrl_cen", 32'(sram_cen), 0);
        @(negedge clk);
        ctrl_bus  = CB_IDLE;
        host_last = 1'b1;
        #1;
        check("rd_gnt", 32'(host_gnt), 1);
        check("rd_a", 32'(sram_a), 32'h40);
        check("rd_wen", 32'(sram_wen), 1);
        check("drain_rd_no_rvalid", 32'(host_rvalid), 0);
        check("drain_core_rdata", 32'(core_rdata), 32'(pat(13'h0101)));
        sb.push_back('{cyc + 1, 16'hBEEF});
        @(negedge clk);
        drive_idle();
        #1;
        check("rd_rel_gnt", 32'(host_gnt), 0);
        repeat (4) @(negedge clk);

        // ---------------- 12-access burst, forced release, gap ----------
        idx = 0;
        for (int t = 0; t < 22; t++) begin
            @(negedge clk);
            ctrl_bus   = CB_IDLE;
            host_req   = (idx < 12);
            host_we    = 1'b1;
            host_addr  = AW'(13'h0300 + idx);
            host_wdata = 16'hD000 + 16'(idx);
            host_last  = (idx == 11);
            #1;
            gnt_exp   = (t >= 2 && t <= 9) || (t >= 17 && t <= 20);
            pause_exp = (t >= 1 && t <= 9) || (t >= 16 && t <= 20);
            check("burst_gnt", 32'(host_gnt), 32'(gnt_exp));
            check("burst_pause", 32'(ctrl_pause), 32'(pause_exp));
            if (gnt_exp) begin
                check("burst_a", 32'(sram_a), 32'h300 + idx);
                idx++;
            end
        end
        drive_idle();
        check("burst_mem", 32'(mem[13'h30B]), 32'hD00B);
        repeat (4) @(negedge clk);

        // ---------------- controller access during HOST -----------------
        @(negedge clk);
        host_req = 1'b1; host_we = 1'b1; host_addr = 13'h0400; host_wdata = 16'hE000;
        #1;
        @(negedge clk);
        #1;
        @(negedge clk);
        ctrl_bus   = cb_wr(13'h0777);
        ctrl_wdata = 16'hDEAD;
        #1;
        check("perr_host_a", 32'(sram_a), 32'h400);
        check("perr_host_d", 32'(sram_d), 32'hE000);
        check("perr_host_wen", 32'(sram_wen), 0);
        check("perr_before", 32'(proto_err), 0);
        @(negedge clk);
        ctrl_bus = CB_IDLE;
        host_addr = 13'h0401; host_wdata = 16'hE001; host_last = 1'b1;
        #1;
        check("perr_set", 32'(proto_err), 1);
        @(negedge clk);
        drive_idle();
        #1;
        check("perr_rel_gnt", 32'(host_gnt), 0);
        repeat (3) @(negedge clk);
        #1;
        check("perr_sticky", 32'(proto_err), 1);
        check("perr_dropped", 32'(mem[13'h777]), 32'(pat(13'h0777)));
        repeat (4) @(negedge clk);

        // ---------------- reset mid-HOST with a read in flight ----------
        @(negedge clk);
        host_req = 1'b1; host_we = 1'b1; host_addr = 13'h0500; host_wdata = 16'hF000;
        #1;
        @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            host_addr = AW'(13'h0500 + i);
            #1;
            check("mid_gnt", 32'(host_gnt), 1);
        end
        @(negedge clk);
        host_we = 1'b0; host_addr = 13'h0203;
        #1;
        check("mid_rd_gnt", 32'(host_gnt), 1);
        sb.push_back('{cyc + 1, 16'hC003});
        @(posedge clk);
        #2;
        rst = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_pause", 32'(ctrl_pause), 0);
        check("mid_rst_gnt", 32'(host_gnt), 0);
        check("mid_rst_rvalid", 32'(host_rvalid), 0);
        check("mid_rst_perr", 32'(proto_err), 0);
        check("mid_rst_rdata", 32'(host_rdata), 0);
        check("mid_rst_cen", 32'(sram_cen), 1);
        check("mid_rst_wen", 32'(sram_wen), 1);
        @(negedge clk);
        drive_idle();
        @(negedge clk);
        rst = 1'b1;
        ctrl_bus = cb_rd(13'h0010);
        #1;
        check("post_rst_a", 32'(sram_a), 32'h10);
        check("post_rst_cen", 32'(sram_cen), 0);
        check("post_rst_wen", 32'(sram_wen), 1);
        check("post_rst_gnt", 32'(host_gnt), 0);
        check("post_rst_pause", 32'(ctrl_pause), 0);
        @(negedge clk);
        ctrl_bus = CB_IDLE;
        #1;
        check("post_rst_core", 32'(core_rdata), 32'(pat(13'h0010)));
        check("post_rst_rvalid", 32'(host_rvalid), 0);

        repeat (3) @(negedge clk);
        #3;
        check("sb_empty", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
